// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the binary-to-BCD display update controller.
package bcd_ctrl_pkg;

    localparam int BIN_W   = 14;
    localparam int MAX_VAL = 9999;
    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;

    // Bit offsets of each digit inside the 28-bit display word
    localparam int TH_LSB = 24;
    localparam int HU_LSB = 20;
    localparam int TE_LSB = 16;
    localparam int UN_LSB = 12;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bcd_update_controller.sv
// Converts a saturated binary result to BCD one bit per cycle and commits it
// to the display word atomically, with a one-cycle done pulse.
module bcd_update_controller #(
    parameter int BIN_W   = bcd_ctrl_pkg::BIN_W,
    parameter int MAX_VAL = bcd_ctrl_pkg::MAX_VAL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [BIN_W-1:0] bin_in,
    output logic             in_ready,
    input  logic             clear,
    output logic [27:0]      BCD_code,
    output logic             done,
    output logic             overflow
);

    import bcd_ctrl_pkg::*;

    localparam int                 CNT_W = $clog2(BIN_W);
    localparam int                 SCR_W = DIGITS * DIGIT_W;
    localparam logic [BIN_W-1:0]   MAX_V = BIN_W'(MAX_VAL);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(BIN_W - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCR_W-1:0]   r_scratch;
    logic [SCR_W-1:0]   w_adj;
    logic [BIN_W-1:0]   r_shift;
    logic               r_sat;
    logic [27:0]        r_bcd;
    logic               r_done;
    logic               r_ovf;
    logic               w_over;

    assign w_over   = (bin_in > MAX_V);
    assign in_ready = (r_state == IDLE);
    assign BCD_code = r_bcd;
    assign done     = r_done;
    assign overflow = r_ovf;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .i_digit (r_scratch[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // clear dominates every state, including a pending acceptance in IDLE
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (in_valid) w_next = CONV;
                CONV:    if (r_cnt == LAST) w_next = COMMIT;
                COMMIT:  w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_scratch <= '0;
            r_shift   <= '0;
            r_sat     <= 1'b0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clear) begin
                r_bcd <= '0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (in_valid) begin
                            r_shift   <= w_over ? MAX_V : bin_in;
                            r_sat     <= w_over;
                            r_scratch <= '0;
                            r_cnt     <= '0;
                        end
                    end
                    CONV: begin
                        {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // Display word changes only here, so no partial result is ever visible
                    COMMIT: begin
                        r_bcd[TH_LSB +: DIGIT_W] <= r_scratch[3*DIGIT_W +: DIGIT_W];
                        r_bcd[HU_LSB +: DIGIT_W] <= r_scratch[2*DIGIT_W +: DIGIT_W];
                        r_bcd[TE_LSB +: DIGIT_W] <= r_scratch[1*DIGIT_W +: DIGIT_W];
                        r_bcd[UN_LSB +: DIGIT_W] <= r_scratch[0 +: DIGIT_W];
                        r_ovf  <= r_sat;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/bcd_update_controller.md
BCD_UPDATE_CONTROLLER -- requirements
Module: bcd_update_controller

Interface
REQ-001 SHALL have parameter BIN_W, default 14: width of the binary result input.
REQ-002 SHALL have parameter MAX_VAL, default 9999: largest value shown on the 4-digit display.
REQ-003 SHALL have port clk, input, 1: single clock for all state; rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: requester offers a binary result.
REQ-006 SHALL have port bin_in, input, BIN_W: unsigned binary result from the multiplier.
REQ-007 SHALL have port in_ready, output, 1: controller can accept a result.
REQ-008 SHALL have port clear, input, 1: synchronous request to blank the display value to 0000.
REQ-009 SHALL have port BCD_code, output, 28: registered display word feeding the 7-segment multiplexer.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when BCD_code has been updated.
REQ-011 SHALL have port overflow, output, 1: the last committed value was saturated.

Function
REQ-012 SHALL place digits at thousands [27:24], hundreds [23:20], tens [19:16] and units [15:12], and SHALL hold [11:0] at zero at all times.
REQ-013 SHALL implement the FSM states IDLE, CONV and COMMIT; in_ready SHALL be 1 only in IDLE.
REQ-014 SHALL accept a result on an edge where in_valid=1, in_ready=1 and clear=0 (edge N); on that edge it SHALL capture min(bin_in, MAX_VAL) into the shift register, zero the BCD scratch, set the iteration count to 0, latch the saturation flag (bin_in>MAX_VAL), and go to CONV.
REQ-015 In CONV, each edge SHALL perform one double-dabble step: add 3 to every scratch digit that is >=5, then shift {scratch, shift reg} left by 1.
REQ-016 CONV SHALL last exactly BIN_W edges (N+1 to N+BIN_W) and SHALL go to COMMIT on the edge where the count equals BIN_W-1.
REQ-017 On the COMMIT edge (N+BIN_W+1), the FSM SHALL load BCD_code from the scratch, load overflow from the latched flag, assert done for exactly that one cycle, and return to IDLE.
REQ-018 SHALL give a latency of BIN_W+1 edges from acceptance to the BCD_code update (15 at the default).
REQ-019 SHALL hold BCD_code and overflow stable during CONV, so the display shows no intermediate values.
REQ-020 With in_valid held high, the next result SHALL be accepted on the first IDLE edge, giving a throughput of one conversion per BIN_W+2 cycles.
REQ-021 clear SHALL override everything: from any state it SHALL set BCD_code=0 and overflow=0, abort any conversion, go to IDLE, and SHALL NOT assert done.
REQ-022 clear and in_valid asserted together in IDLE: clear SHALL win, and the request SHALL NOT be accepted on that edge.
REQ-023 A change of bin_in or in_valid after acceptance SHALL have no effect on the running conversion.

Reset
REQ-024 While reset=0, the block SHALL asynchronously force: state IDLE, BCD_code=28'h0, done=0, overflow=0, iteration count 0 and scratch 0.
REQ-025 Reset asserted mid-conversion SHALL discard the conversion, and no done pulse SHALL follow reset release.
REQ-026 in_ready SHALL read 1 on the first cycle after reset is released.

Structure
REQ-027 Package bcd_ctrl_pkg SHALL hold: the state enum (IDLE, CONV, COMMIT), BIN_W, MAX_VAL, DIGITS=4, and the digit bit offsets of BCD_code.
REQ-028 The combinational per-digit add-3 adjust SHALL be the sub-module bcd_add3_digit, instantiated DIGITS times.
REQ-029 The iteration counter SHALL be $clog2(BIN_W) bits wide and SHALL reset to 0 on acceptance.

Verification
REQ-030 bin_in=1234 accepted at edge N -> BCD_code=28'h1234000 at edge N+15, done high for one cycle, overflow=0.
REQ-031 bin_in=0, then bin_in=9999 back-to-back with in_valid held high -> 28'h0000000, then 28'h9999000, with the second acceptance 16 cycles after the first.
REQ-032 bin_in=12000 -> BCD_code=28'h9999000 and overflow=1; a following bin_in=7 -> 28'h0007000 and overflow=0.
REQ-033 clear pulsed at CONV iteration 5 -> BCD_code=0, no done pulse, in_ready=1 on the next cycle; clear together with in_valid in IDLE -> request not accepted.
REQ-034 reset asserted mid-conversion, asynchronously between edges -> outputs reach their reset values immediately, and no done pulse follows release.
REQ-035 Bench SHALL compare every committed value against a reference BCD model over 1000 random bin_in values in 0..16383, and check that BCD_code[11:0] stays 0 throughout.
